// File: rtl/median_window_fifo_pkg.sv
// Shared sizing for the median window front-end.
// Supplies the shared DATA_LENGTH / WMAX / LOG_WMAX macros when the project-wide
// macro set has not already been defined earlier in the compile.
`ifndef DATA_LENGTH
`define DATA_LENGTH 16
`endif
`ifndef WMAX
`define WMAX 8
`endif
`ifndef LOG_WMAX
`define LOG_WMAX 3
`endif

package median_window_fifo_pkg;

  localparam int unsigned DEF_DATA_LENGTH = `DATA_LENGTH;
  localparam int unsigned DEF_WMAX        = `WMAX;
  localparam int unsigned DEF_LOG_WMAX    = `LOG_WMAX;

  // Clamp a requested window size into 1..wmax; out-of-range requests take the maximum.
  function automatic int unsigned clamp_window(input int unsigned req, input int unsigned wmax);
    if (req == 0 || req > wmax) return wmax;
    return req;
  endfunction

endpackage

// File: rtl/median_window_fifo_window_ram.sv
// Sample storage for the sliding window: one write port, one combinational read port.
module window_ram
  import median_window_fifo_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = `DATA_LENGTH,
  parameter int unsigned WMAX        = `WMAX,
  parameter int unsigned LOG_WMAX    = `LOG_WMAX
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [LOG_WMAX-1:0]    addr,
  input  logic [DATA_LENGTH-1:0] wdata,
  output logic [DATA_LENGTH-1:0] rdata
);

  logic [DATA_LENGTH-1:0] mem [WMAX];

  // Write the accepted sample; contents are intentionally never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read returns the old entry at addr before any same-cycle overwrite.
  assign rdata = mem[addr];

endmodule

// File: rtl/median_window_fifo.sv
// Sliding-window sample FIFO feeding the median cell array: emits the new sample
// and, once the window is full, the sample that falls out of it.
module median_window_fifo
  import median_window_fifo_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = `DATA_LENGTH,
  parameter int unsigned WMAX        = `WMAX,
  parameter int unsigned LOG_WMAX    = `LOG_WMAX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_load,
  input  logic [LOG_WMAX:0]      w,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_LENGTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LENGTH-1:0] x_out,
  output logic [DATA_LENGTH-1:0] r_old_out,
  output logic                   evict,
  output logic [LOG_WMAX:0]      fill,
  output logic                   cfg_err
);

  localparam int unsigned PW = LOG_WMAX;
  localparam int unsigned FW = LOG_WMAX + 1;
  localparam logic [FW-1:0] WMAX_F = FW'(WMAX);

  logic [FW-1:0]          w_reg, nxt_w_reg;
  logic [PW-1:0]          wr_ptr, nxt_wr_ptr;
  logic [FW-1:0]          nxt_fill;
  logic                   nxt_out_valid, nxt_evict, nxt_cfg_err;
  logic [DATA_LENGTH-1:0] nxt_x_out, nxt_r_old_out;
  logic [DATA_LENGTH-1:0] rd_data;
  logic                   accept_c;
  logic                   full_c;
  logic                   ptr_last_c;
  logic                   w_bad_c;

  // Upstream may push only when the output slot is free or draining this cycle.
  assign in_ready   = !reset && !cfg_load && (!out_valid || out_ready);
  assign accept_c   = in_valid && in_ready;
  assign full_c     = (fill >= w_reg);
  assign ptr_last_c = ({1'b0, wr_ptr} == (w_reg - FW'(1)));
  assign w_bad_c    = (w == '0) || (w > WMAX_F);

  window_ram #(
    .DATA_LENGTH(DATA_LENGTH),
    .WMAX       (WMAX),
    .LOG_WMAX   (LOG_WMAX)
  ) u_ram (
    .clk  (clk),
    .we   (accept_c),
    .addr (wr_ptr),
    .wdata(in_data),
    .rdata(rd_data)
  );

  // Next-state: cfg_load flushes, otherwise accept a sample or drain the output.
  always_comb begin
    nxt_w_reg     = w_reg;
    nxt_wr_ptr    = wr_ptr;
    nxt_fill      = fill;
    nxt_out_valid = out_valid;
    nxt_x_out     = x_out;
    nxt_r_old_out = r_old_out;
    nxt_evict     = evict;
    nxt_cfg_err   = 1'b0;

    if (cfg_load) begin
      nxt_w_reg     = w_bad_c ? WMAX_F : w;
      nxt_cfg_err   = w_bad_c;
      nxt_wr_ptr    = '0;
      nxt_fill      = '0;
      nxt_out_valid = 1'b0;
    end else if (accept_c) begin
      nxt_out_valid = 1'b1;
      nxt_x_out     = in_data;
      nxt_wr_ptr    = ptr_last_c ? '0 : wr_ptr + PW'(1);
      if (full_c) begin
        nxt_evict     = 1'b1;
        nxt_r_old_out = rd_data;
      end else begin
        nxt_evict     = 1'b0;
        nxt_r_old_out = '0;
        nxt_fill      = fill + FW'(1);
      end
    end else if (out_ready) begin
      nxt_out_valid = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_reg     <= WMAX_F;
      wr_ptr    <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
      r_old_out <= '0;
      evict     <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      w_reg     <= nxt_w_reg;
      wr_ptr    <= nxt_wr_ptr;
      fill      <= nxt_fill;
      out_valid <= nxt_out_valid;
      x_out     <= nxt_x_out;
      r_old_out <= nxt_r_old_out;
      evict     <= nxt_evict;
      cfg_err   <= nxt_cfg_err;
    end
  end

endmodule

// File: tb/tb_median_window_fifo.sv
// Directed bench for median_window_fifo with hand-computed expectations.
module tb_median_window_fifo;

  localparam int unsigned DL = 16;
  localparam int unsigned WM = 8;
  localparam int unsigned LW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_load;
  logic [LW:0]   w;
  logic          in_valid;
  logic          in_ready;
  logic [DL-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DL-1:0] x_out;
  logic [DL-1:0] r_old_out;
  logic          evict;
  logic [LW:0]   fill;
  logic          cfg_err;

  int vectors = 0;
  int errors  = 0;

  median_window_fifo #(.DATA_LENGTH(DL), .WMAX(WM), .LOG_WMAX(LW)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_load (cfg_load),
    .w        (w),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .r_old_out(r_old_out),
    .evict    (evict),
    .fill     (fill),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for one edge (accepted only if in_ready is high).
  task automatic send(input logic [DL-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [LW:0] req);
    cfg_load = 1'b1;
    w        = req;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int x, input int ev, input int ro, input int f);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".x"},     32'(x_out),     32'(x));
    chk({tag, ".evict"}, 32'(evict),     32'(ev));
    chk({tag, ".r_old"}, 32'(r_old_out), 32'(ro));
    chk({tag, ".fill"},  32'(fill),      32'(f));
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; w = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    // Reset state
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.fill",      32'(fill),      32'd0);
    chk("rst.evict",     32'(evict),     32'd0);
    chk("rst.x",         32'(x_out),     32'd0);
    chk("rst.r_old",     32'(r_old_out), 32'd0);
    chk("rst.cfg_err",   32'(cfg_err),   32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    // Window of 3: first eviction on sample 4
    cfg(4'd3);
    chk("w3.cfg_err", 32'(cfg_err), 32'd0);
    chk("w3.fill",    32'(fill),    32'd0);
    send(16'd10); chk_out("w3.s1", 10, 0, 0, 1);
    send(16'd20); chk_out("w3.s2", 20, 0, 0, 2);
    send(16'd30); chk_out("w3.s3", 30, 0, 0, 3);
    send(16'd40); chk_out("w3.s4", 40, 1, 10, 3);
    send(16'd50); chk_out("w3.s5", 50, 1, 20, 3);
    send(16'd60); chk_out("w3.s6", 60, 1, 30, 3);
    send(16'd70); chk_out("w3.s7", 70, 1, 40, 3);

    // Backpressure: sample 7 held, sample 8 waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'd80;
    #1;
    chk("bp.in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bp.hold", 70, 1, 40, 3);
      chk("bp.in_ready_hold", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("bp.s8", 80, 1, 50, 3);
    tick();
    chk("bp.drained", 32'(out_valid), 32'd0);

    // Out-of-range window requests clamp to WMAX
    cfg(4'd0);
    chk("w0.cfg_err", 32'(cfg_err), 32'd1);
    tick();
    chk("w0.cfg_err_pulse", 32'(cfg_err), 32'd0);
    cfg(4'(WM + 1));
    chk("w9.cfg_err", 32'(cfg_err), 32'd1);
    chk("w9.fill",    32'(fill),    32'd0);
    for (int i = 1; i <= WM; i++) begin
      send(16'(i));
      chk_out("wmax.fillup", i, 0, 0, i);
    end
    chk("wmax.cfg_err_low", 32'(cfg_err), 32'd0);
    send(16'd9); chk_out("wmax.s9", 9, 1, 1, WM);

    // cfg_load beats a simultaneous sample
    cfg(4'd4);
    for (int i = 1; i <= 6; i++) send(16'(100 + i));
    chk_out("w4.s6", 106, 1, 102, 4);
    cfg_load = 1'b1; w = 4'd4; in_valid = 1'b1; in_data = 16'd200;
    #1;
    chk("coll.in_ready", 32'(in_ready), 32'd0);
    tick();
    cfg_load = 1'b0; in_valid = 1'b0;
    chk("coll.fill",      32'(fill),      32'd0);
    chk("coll.out_valid", 32'(out_valid), 32'd0);
    send(16'd201); chk_out("coll.next", 201, 0, 0, 1);

    // Reset mid-stream discards pending output and window
    send(16'd202);
    chk("mid.pending", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b1;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.fill",      32'(fill),      32'd0);
    chk("mid.evict",     32'(evict),     32'd0);
    send(16'd300); chk_out("mid.first", 300, 0, 0, 1);

    // Window of 1
    cfg(4'd1);
    send(16'd5); chk_out("w1.s1", 5, 0, 0, 1);
    send(16'd6); chk_out("w1.s2", 6, 1, 5, 1);
    send(16'd7); chk_out("w1.s3", 7, 1, 6, 1);
    tick();
    chk("w1.drained", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/median_window_fifo.md
MEDIAN_WINDOW_FIFO -- requirements
Module: median_window_fifo

Interface
REQ-001 SHALL have parameters: DATA_LENGTH, default `DATA_LENGTH, sample width; WMAX, default `WMAX, maximum window depth; LOG_WMAX, default `LOG_WMAX, pointer width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cfg_load  input  1  pulse: latch w and flush window.
REQ-005 SHALL have port w  input  LOG_WMAX+1  requested window size.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  sample accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port in_data  input  DATA_LENGTH  new sample.
REQ-009 SHALL have port out_valid  output  1  x_out/r_old_out/evict valid; one cell-array update step.
REQ-010 SHALL have port out_ready  input  1  cell array consumes the step.
REQ-011 SHALL have port x_out  output  DATA_LENGTH  new sample broadcast to cells (X).
REQ-012 SHALL have port r_old_out  output  DATA_LENGTH  sample leaving the window (R_old); 0 when evict=0.
REQ-013 SHALL have port evict  output  1  window full; r_old_out is a real departing sample.
REQ-014 SHALL have port fill  output  LOG_WMAX+1  number of samples currently in the window.
REQ-015 SHALL have port cfg_err  output  1  one-cycle pulse when the latched w is out of range.

Function
REQ-016 SHALL store samples in a circular buffer of WMAX entries; write pointer wr_ptr wraps at w_reg-1 to 0.
REQ-017 SHALL set in_ready = !out_valid || out_ready, forced to 0 while reset or cfg_load is high.
REQ-018 On acceptance with fill < w_reg: write mem[wr_ptr], advance wr_ptr, increment fill, and emit x_out=in_data, evict=0, r_old_out=0.
REQ-019 On acceptance with fill == w_reg: read mem[wr_ptr] into r_old_out in the same cycle, overwrite it with in_data, advance wr_ptr, hold fill, and emit evict=1.
REQ-020 SHALL register the outputs: out_valid rises on the clock edge following acceptance (latency 1).
REQ-021 SHALL hold out_valid and all output data stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid after the out_ready handshake unless a new sample is accepted in the same cycle (back-to-back throughput: 1 sample per clock).
REQ-023 On cfg_load: w_reg<=w, with w==0 or w>WMAX replaced by WMAX plus a cfg_err pulse; wr_ptr<=0; fill<=0; out_valid<=0.
REQ-024 SHALL give cfg_load priority over a simultaneous in_valid; that sample is not accepted.
REQ-025 With w_reg==1: every accepted sample after the first SHALL evict the previous sample.

Reset
REQ-026 On reset: out_valid=0, x_out=0, r_old_out=0, evict=0, fill=0, cfg_err=0, wr_ptr=0, w_reg=WMAX; buffer contents are not cleared.
REQ-027 Reset mid-stream SHALL discard the pending output and all window contents; the first sample after reset SHALL have evict=0.

Structure
REQ-028 DATA_LENGTH, WMAX, and LOG_WMAX SHALL come from the shared macro.vh; no local redefinition.
REQ-029 The buffer SHALL be one sub-module, window_ram (WMAX x DATA_LENGTH, 1 write port, 1 combinational read port).
REQ-030 x_out, r_old_out, and out_valid SHALL connect directly to the X, R_old, and step-enable inputs of the median cell array.

Verification
REQ-031 Reset, cfg_load w=3, feed 10,20,30,40,50 with out_ready=1 -> evict 0,0,0,1,1; r_old_out at samples 4 and 5 = 10,20; fill 1,2,3,3,3.
REQ-032 w=3, hold out_ready=0 after sample 7 -> in_ready=0, outputs frozen; raise out_ready -> sample 7 delivered once, no loss or duplication.
REQ-033 cfg_load w=0, then w=WMAX+1 -> cfg_err pulses each time; w_reg=WMAX; evict first seen on sample WMAX+1.
REQ-034 w=4 with 6 samples loaded, assert cfg_load together with in_valid -> sample rejected, fill=0, next sample gives evict=0.
REQ-035 Assert reset mid-stream with out_valid=1 -> next cycle out_valid=0, fill=0.
REQ-036 w=1, feed 5,6,7 -> evict 0,1,1; r_old_out 0,5,6.
